// File: rtl/entropy_harvester_pkg.sv
// entropy_harvester_pkg: shared FSM state type, default timing/health constants and byte width.
package entropy_harvester_pkg;
    typedef enum logic [1:0] {IDLE, EXCITE, SETTLE, SAMPLE} state_t;
    localparam int DEF_EXCITE_CYCLES = 2;
    localparam int DEF_SETTLE_CYCLES = 3;
    localparam int DEF_REP_LIMIT     = 32;
    localparam int BYTE_W            = 8;
endpackage

// File: rtl/entropy_harvester_if.sv
// entropy_harvester_if: valid/ready byte stream from the harvester to its consumer.
interface entropy_harvester_if;
    import entropy_harvester_pkg::*;
    logic [BYTE_W-1:0] rnd_byte;
    logic              rnd_valid;
    logic              rnd_ready;
    modport master (output rnd_byte, output rnd_valid, input rnd_ready);
    modport slave  (input rnd_byte, input rnd_valid, output rnd_ready);
endinterface

// File: rtl/entropy_harvester_vn_debias.sv
// vn_debias: von Neumann pairing; 01 -> 0, 10 -> 1, equal pairs dropped.
module vn_debias (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic in_valid,
    input  logic in_bit,
    output logic out_valid,
    output logic out_bit
);
    logic have, first;

    // the completing sample still emits in the cycle the pair is cleared
    assign out_valid = in_valid && have && (first != in_bit);
    assign out_bit   = first;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            have  <= 1'b0;
            first <= 1'b0;
        end else if (in_valid) begin
            have  <= !have;
            first <= in_bit;
        end
    end
endmodule

// File: rtl/entropy_harvester.sv
// entropy_harvester: drives a random-latch cell through excite/settle/sample cycles,
// debiases the samples, packs them into bytes and monitors repetition health.
module entropy_harvester
    import entropy_harvester_pkg::*;
#(
    parameter int EXCITE_CYCLES = DEF_EXCITE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic raw_bit,
    output logic gen_g,
    output logic health_fail,
    entropy_harvester_if.master rnd
);
    localparam int CNT_W = $clog2((EXCITE_CYCLES > SETTLE_CYCLES ? EXCITE_CYCLES : SETTLE_CYCLES) + 1);
    localparam int REP_W = $clog2(REP_LIMIT + 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              sync1, sync2, prev;
    logic [REP_W-1:0]  rep, rep_next;
    logic [BYTE_W-1:0] pack, pack_next;
    logic [2:0]        bit_cnt;
    logic              pack_full;
    logic              sampling, fail_now, emit, vn_bit, byte_done, can_xfer, go, vn_clear;

    assign sampling  = state == SAMPLE;
    assign rep_next  = (sync2 == prev) ? rep + 1'b1 : REP_W'(1);
    assign fail_now  = sampling && rep_next >= REP_W'(REP_LIMIT);
    assign byte_done = emit && bit_cnt == 3'd7;
    assign can_xfer  = !rnd.rnd_valid || rnd.rnd_ready;
    // an 8th bit that cannot reach the output buffer parks the FSM in IDLE
    assign go        = enable && !health_fail && !pack_full && !fail_now && !(byte_done && !can_xfer);
    assign vn_clear  = sampling && !go;

    always_comb begin
        pack_next          = pack;
        pack_next[bit_cnt] = vn_bit;
    end

    vn_debias u_vn (
        .clk(clk),
        .rst(rst),
        .clear(vn_clear),
        .in_valid(sampling),
        .in_bit(sync2),
        .out_valid(emit),
        .out_bit(vn_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            gen_g <= 1'b1;
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw_bit;
            sync2 <= sync1;
            case (state)
                IDLE: if (go) begin
                    state <= EXCITE;
                    cnt   <= CNT_W'(EXCITE_CYCLES - 1);
                    gen_g <= 1'b0;
                end
                EXCITE: if (cnt == '0) begin
                    state <= SETTLE;
                    cnt   <= CNT_W'(SETTLE_CYCLES - 1);
                    gen_g <= 1'b1;
                end else cnt <= cnt - 1'b1;
                SETTLE: if (cnt == '0) state <= SAMPLE;
                        else cnt <= cnt - 1'b1;
                SAMPLE: begin
                    state <= go ? EXCITE : IDLE;
                    cnt   <= CNT_W'(EXCITE_CYCLES - 1);
                    gen_g <= !go;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev          <= 1'b0;
            rep           <= '0;
            health_fail   <= 1'b0;
            pack          <= '0;
            bit_cnt       <= '0;
            pack_full     <= 1'b0;
            rnd.rnd_byte  <= '0;
            rnd.rnd_valid <= 1'b0;
        end else begin
            if (sampling) begin
                prev <= sync2;
                rep  <= rep_next;
            end
            if (fail_now) health_fail <= 1'b1;
            if (rnd.rnd_valid && rnd.rnd_ready) rnd.rnd_valid <= 1'b0;
            if (fail_now) begin
                pack      <= '0;
                bit_cnt   <= '0;
                pack_full <= 1'b0;
            end else if (pack_full && can_xfer) begin
                rnd.rnd_byte  <= pack;
                rnd.rnd_valid <= 1'b1;
                pack_full     <= 1'b0;
            end else if (emit) begin
                pack    <= pack_next;
                bit_cnt <= bit_cnt + 1'b1;
                if (byte_done && can_xfer) begin
                    rnd.rnd_byte  <= pack_next;
                    rnd.rnd_valid <= 1'b1;
                end else if (byte_done) pack_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_entropy_harvester.sv
// tb_entropy_harvester: random and directed stimulus against a queue-based
// von Neumann/packing reference model.
module tb_entropy_harvester;
    logic clk = 1'b0, rst = 1'b1, enable = 1'b0, raw_bit = 1'b0;
    logic gen_g, health_fail;
    entropy_harvester_if bus();

    entropy_harvester dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .raw_bit(raw_bit),
        .gen_g(gen_g),
        .health_fail(health_fail),
        .rnd(bus)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int script[$];
    int samp[$];
    logic [7:0] got[$], exp_q[$];
    int n_drv = 0, ready_mode = 0;
    bit stuck = 1'b0;
    logic g_prev = 1'b1;

    task automatic chk(string tag, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, req);
        end
    endtask

    // latch cell: a new value appears each time G is released after excitation
    initial forever begin
        int v;
        @(negedge clk);
        if (gen_g && !g_prev) begin
            if (script.size() > 0) v = script.pop_front();
            else if (stuck) v = 1;
            else v = int'($urandom_range(0, 1));
            raw_bit = v[0];
            samp.push_back(v);
            n_drv++;
        end
        g_prev = gen_g;
    end

    initial begin
        bus.rnd_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.rnd_ready = (ready_mode == 2) ? ($urandom_range(0, 1) == 1) : (ready_mode == 1);
            if (bus.rnd_valid && bus.rnd_ready) got.push_back(bus.rnd_byte);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        step(2);
        rst = 1'b0;
        samp.delete();
        script.delete();
        got.delete();
        n_drv = 0;
        stuck = 1'b0;
    endtask

    task automatic push_byte(logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            script.push_back(b[i] ? 1 : 0);
            script.push_back(b[i] ? 0 : 1);
        end
    endtask

    // what: 0 = driven samples, 1 = received bytes, 2 = health_fail, 3 = rnd_valid
    task automatic wait_for(string tag, int what, int n, int limit);
        int i;
        for (i = 0; i < limit; i++) begin
            if ((what == 0 && n_drv >= n) || (what == 1 && got.size() >= n) ||
                (what == 2 && health_fail) || (what == 3 && bus.rnd_valid)) break;
            step(1);
        end
        if (i == limit) chk({tag, "_timeout"}, 0, 1);
    endtask

    // reference: pair samples, emit first of unequal pairs, pack LSB first; 2 marks a pair reset
    task automatic build_exp();
        int have = 0, first = 0, n = 0;
        logic [7:0] acc = 8'h00;
        exp_q.delete();
        foreach (samp[i]) begin
            if (samp[i] == 2) have = 0;
            else if (have == 0) begin
                first = samp[i];
                have = 1;
            end else begin
                have = 0;
                if (first != samp[i]) begin
                    acc[n] = first[0];
                    n++;
                    if (n == 8) begin
                        exp_q.push_back(acc);
                        n = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        int lo, hi, v;
        step(3);
        chk("reset_gen_g", gen_g, 1);
        chk("reset_valid", bus.rnd_valid, 0);
        chk("reset_byte", bus.rnd_byte, 0);
        chk("reset_health", health_fail, 0);

        do_reset();
        ready_mode = 1;
        enable = 1'b1;
        for (int i = 0; i < 20 && gen_g; i++) step(1);
        lo = 0;
        hi = 0;
        while (!gen_g && lo < 20) begin lo++; step(1); end
        while (gen_g && hi < 20) begin hi++; step(1); end
        chk("excite_len", lo, 2);
        chk("settle_sample_len", hi, 4);
        enable = 1'b0;
        step(10);

        do_reset();
        ready_mode = 0;
        script = '{0,1,1,0,0,0,1,1,0,1,0,1,0,1,1,0,1,0,1,0};
        enable = 1'b1;
        wait_for("debias", 3, 0, 400);
        chk("debias_byte", bus.rnd_byte, 8'hE2);
        chk("debias_valid", bus.rnd_valid, 1);

        push_byte(8'h5B);
        wait_for("bp_drv", 0, 36, 600);
        lo = 0;
        repeat (30) begin step(1); lo += int'(!gen_g); end
        chk("bp_idle_low", lo, 0);
        chk("bp_no_samples", n_drv, 36);
        chk("bp_hold_byte", bus.rnd_byte, 8'hE2);
        chk("bp_hold_valid", bus.rnd_valid, 1);
        ready_mode = 1;
        step(1);
        chk("bp_second_byte", bus.rnd_byte, 8'h5B);
        chk("bp_second_valid", bus.rnd_valid, 1);
        chk("bp_first_got", got.size() > 0 ? got[0] : 8'h00, 8'hE2);
        enable = 1'b0;
        step(20);
        chk("bp_got_count", got.size(), 2);

        do_reset();
        ready_mode = 2;
        repeat (4) begin
            enable = 1'b1;
            step(int'($urandom_range(300, 900)));
            enable = 1'b0;
            step(12);
            samp.push_back(2);
        end
        ready_mode = 1;
        step(20);
        build_exp();
        chk("rand_count", got.size(), exp_q.size());
        foreach (exp_q[i]) chk("rand_byte", i < got.size() ? got[i] : 8'h00, exp_q[i]);

        do_reset();
        ready_mode = 0;
        script = '{0,1,1,0,0,0,1,1,0,1,0,1,0,1,1,0,1,0,1,0};
        stuck = 1'b1;
        enable = 1'b1;
        wait_for("health", 2, 0, 2000);
        chk("health_samples", n_drv, 52);
        chk("health_pending_valid", bus.rnd_valid, 1);
        chk("health_pending_byte", bus.rnd_byte, 8'hE2);
        step(40);
        chk("health_no_more_samples", n_drv, 52);
        chk("health_gen_g", gen_g, 1);
        ready_mode = 1;
        step(3);
        chk("health_delivered", got.size() > 0 ? got[0] : 8'h00, 8'hE2);
        v = 0;
        repeat (40) begin step(1); v += int'(bus.rnd_valid); end
        chk("health_no_valid", v, 0);
        chk("health_sticky", health_fail, 1);

        do_reset();
        ready_mode = 0;
        push_byte(8'h96);
        script.push_back(1); script.push_back(0);
        script.push_back(0); script.push_back(1);
        script.push_back(1); script.push_back(0);
        script.push_back(1); script.push_back(0);
        script.push_back(0); script.push_back(1);
        script.push_back(1);
        enable = 1'b1;
        wait_for("midrst", 0, 27, 800);
        chk("midrst_pending", bus.rnd_valid, 1);
        rst = 1'b1;
        step(1);
        chk("midrst_gen_g", gen_g, 1);
        chk("midrst_valid", bus.rnd_valid, 0);
        chk("midrst_byte", bus.rnd_byte, 0);
        chk("midrst_health", health_fail, 0);
        script.delete();
        samp.delete();
        push_byte(8'h3C);
        n_drv = 0;
        got.delete();
        ready_mode = 1;
        rst = 1'b0;
        wait_for("midrst_fresh", 1, 1, 400);
        chk("midrst_fresh_byte", got.size() > 0 ? got[0] : 8'h00, 8'h3C);
        enable = 1'b0;
        step(12);

        do_reset();
        ready_mode = 1;
        script = '{0,1,1};
        enable = 1'b1;
        wait_for("endrop", 0, 3, 200);
        enable = 1'b0;
        lo = 0;
        repeat (20) begin step(1); lo += int'(!gen_g); end
        chk("endrop_idle_low", lo, 0);
        chk("endrop_samples", n_drv, 3);
        script = '{1,0,0,1,1,0,0,1,1,0,0,1,1,0};
        enable = 1'b1;
        wait_for("endrop_byte", 1, 1, 500);
        chk("endrop_pair_cleared", got.size() > 0 ? got[0] : 8'h00, 8'hAA);
        enable = 1'b0;
        step(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
